// File: rtl/vc_sched_pkg.sv
// vc_sched_pkg: shared encodings for the VC scheduler controller
package vc_sched_pkg;
    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_t;
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;
    localparam int CRW = 4;
endpackage

// File: rtl/vc_sched_ctrl_wrr_grant.sv
// wrr_grant: weighted round-robin pop selection with pointer/credit registers
module wrr_grant
    import vc_sched_pkg::*;
#(
    parameter int W0 = 3,
    parameter int W1 = 1
) (
    input  logic clk,
    input  logic reset_L,
    input  logic en,
    input  logic clr,
    input  logic vc0_empty,
    input  logic vc1_empty,
    output logic rd0,
    output logic rd1
);
    logic ptr, ptr_n, cur_empty, oth_empty, sw, g_cur, g_oth;
    logic [CRW-1:0] cr, cr_n, w;
    // pick the current VC until its credit is spent, then hand over to the other
    always_comb begin
        w         = ptr == VC1 ? CRW'(W1) : CRW'(W0);
        cur_empty = ptr == VC1 ? vc1_empty : vc0_empty;
        oth_empty = ptr == VC1 ? vc0_empty : vc1_empty;
        sw        = cur_empty || cr >= w;
        g_oth     = sw && !oth_empty;
        g_cur     = !cur_empty && !g_oth;
        ptr_n     = g_oth ? ~ptr : ptr;
        cr_n      = (g_oth || (sw && g_cur)) ? CRW'(1) : g_cur ? cr + CRW'(1) : cr;
        rd0       = en && (g_cur || g_oth) && ptr_n == VC0;
        rd1       = en && (g_cur || g_oth) && ptr_n == VC1;
    end
    // credit/pointer advance only on granted cycles; reconfiguration clears credit
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= VC0;
            cr  <= '0;
        end else if (clr) begin
            cr  <= '0;
        end else if (en) begin
            ptr <= ptr_n;
            cr  <= cr_n;
        end
    end
endmodule

// File: rtl/vc_sched_ctrl.sv
// vc_sched_ctrl: config FSM, threshold distribution and WRR pop of VC0/VC1
module vc_sched_ctrl
    import vc_sched_pkg::*;
#(
    parameter int BW  = 6,
    parameter int LEN = 4,
    parameter int W0  = 3,
    parameter int W1  = 1
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic           init,
    input  logic [LEN-1:0] umbral_bajo_in,
    input  logic [LEN-1:0] umbral_alto_in,
    input  logic           vc0_empty,
    input  logic           vc1_empty,
    input  logic [BW-1:0]  vc0_data,
    input  logic [BW-1:0]  vc1_data,
    input  logic           dst0_almost_full,
    input  logic           dst1_almost_full,
    input  logic           fifo_error,
    output logic           vc0_rd,
    output logic           vc1_rd,
    output logic [BW-1:0]  data_out,
    output logic           valid_out,
    output logic [LEN-1:0] umbral_bajo,
    output logic [LEN-1:0] umbral_alto,
    output logic [2:0]     state,
    output logic           idle_out,
    output logic           error_out
);
    state_t st, nxt;
    logic   en;
    assign state = st;
    assign en    = st == ACTIVE && !init && !fifo_error && !(dst0_almost_full || dst1_almost_full);
    wrr_grant #(.W0(W0), .W1(W1)) u_wrr (
        .clk       (clk),
        .reset_L   (reset_L),
        .en        (en),
        .clr       (init),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .rd0       (vc0_rd),
        .rd1       (vc1_rd)
    );
    // next state: error beats init beats the idle/active traffic moves
    always_comb begin
        nxt = st == RESET                                  ? INIT   :
              (fifo_error || st == ERROR)                  ? ERROR  :
              init                                         ? INIT   :
              st == INIT                                   ? IDLE   :
              (st == IDLE && !(vc0_empty && vc1_empty))    ? ACTIVE :
              (st == ACTIVE && vc0_empty && vc1_empty)     ? IDLE   : st;
    end
    // FSM state, status flags and threshold registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st          <= RESET;
            idle_out    <= 1'b0;
            error_out   <= 1'b0;
            umbral_bajo <= '0;
            umbral_alto <= '0;
        end else begin
            st        <= nxt;
            idle_out  <= nxt == IDLE;
            error_out <= nxt == ERROR;
            if (st == INIT && init && !fifo_error) begin
                umbral_bajo <= umbral_bajo_in;
                umbral_alto <= umbral_alto_in;
            end
        end
    end
    // register the popped word one cycle after the pop
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= vc0_rd || vc1_rd;
            if (vc0_rd) data_out <= vc0_data;
            else if (vc1_rd) data_out <= vc1_data;
        end
    end
endmodule

// File: tb/tb_vc_sched_ctrl.sv
// tb_vc_sched_ctrl: directed checks of config FSM, WRR order, stall, error and init
module tb_vc_sched_ctrl;
    logic       clk = 1'b0, reset_L, init, vc0_empty, vc1_empty;
    logic       dst0_almost_full, dst1_almost_full, fifo_error;
    logic [3:0] umbral_bajo_in, umbral_alto_in, umbral_bajo, umbral_alto;
    logic [5:0] vc0_data, vc1_data, data_out;
    logic       vc0_rd, vc1_rd, valid_out, idle_out, error_out;
    logic [2:0] state;
    logic       cap0, cap1;
    logic [5:0] q0[$], q1[$];
    int         n_vec = 0, n_err = 0;
    logic [5:0] exp_wrr [16] = '{6'h01, 6'h02, 6'h03, 6'h11, 6'h04, 6'h05, 6'h06, 6'h12,
                                 6'h07, 6'h08, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18};
    logic [5:0] exp_bp [9]    = '{6'h21, 6'h22, 6'h23, 6'h31, 6'h24, 6'h25, 6'h26, 6'h32, 6'h33};
    logic [5:0] exp_ini [7]   = '{6'h03, 6'h04, 6'h05, 6'h3A, 6'h06, 6'h3B, 6'h3C};

    vc_sched_ctrl dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_bajo_in(umbral_bajo_in), .umbral_alto_in(umbral_alto_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .dst0_almost_full(dst0_almost_full), .dst1_almost_full(dst1_almost_full),
        .fifo_error(fifo_error), .vc0_rd(vc0_rd), .vc1_rd(vc1_rd),
        .data_out(data_out), .valid_out(valid_out),
        .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .state(state), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        vc0_empty = q0.size() == 0;
        vc1_empty = q1.size() == 0;
        vc0_data  = vc0_empty ? 6'h0 : q0[0];
        vc1_data  = vc1_empty ? 6'h0 : q1[0];
    endtask

    task automatic load(input int vc, input logic [5:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (vc == 0) q0.push_back(base + 6'(i));
            else q1.push_back(base + 6'(i));
        end
        refresh();
    endtask

    // capture the pop decision just before the edge, then let the FIFO models pop
    task automatic tick();
        #1;
        cap0 = vc0_rd;
        cap1 = vc1_rd;
        if (cap0 && cap1) chk("rd_both", 2'b11, 2'b00);
        @(posedge clk);
        #1;
        if (cap0 && q0.size() > 0) void'(q0.pop_front());
        if (cap1 && q1.size() > 0) void'(q1.pop_front());
        refresh();
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; fifo_error = 1'b0;
        dst0_almost_full = 1'b0; dst1_almost_full = 1'b0;
        umbral_bajo_in = 4'd0; umbral_alto_in = 4'd0;
        refresh();
        #2;
        chk("rst_state", state, 3'd0);
        chk("rst_idle", idle_out, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_alto", umbral_alto, 4'd0);
        // configuration
        init = 1'b1; umbral_alto_in = 4'd3; umbral_bajo_in = 4'd1; reset_L = 1'b1;
        tick();
        chk("cfg_state_init", state, 3'd1);
        chk("cfg_alto_early", umbral_alto, 4'd0);
        tick();
        chk("cfg_alto", umbral_alto, 4'd3);
        chk("cfg_bajo", umbral_bajo, 4'd1);
        init = 1'b0;
        tick();
        chk("cfg_state_idle", state, 3'd2);
        chk("cfg_idle_out", idle_out, 1'b1);
        // weighted order 3:1
        load(0, 6'h01, 8);
        load(1, 6'h11, 8);
        tick();
        chk("wrr_active", state, 3'd3);
        chk("wrr_nopop_idle", valid_out, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("wrr_valid", valid_out, 1'b1);
            chk("wrr_data", data_out, exp_wrr[i]);
        end
        tick();
        chk("wrr_back_idle", state, 3'd2);
        chk("wrr_valid_drop", valid_out, 1'b0);
        chk("wrr_data_hold", data_out, 6'h18);
        // single VC
        load(1, 6'h19, 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("one_rd1", cap1, 1'b1);
            chk("one_rd0", cap0, 1'b0);
            chk("one_data", data_out, 6'h19 + 6'(i));
        end
        tick();
        chk("one_rd1_end", cap1, 1'b0);
        chk("one_idle", state, 3'd2);
        // backpressure
        load(0, 6'h21, 6);
        load(1, 6'h31, 3);
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_pre_data", data_out, exp_bp[i]);
        end
        dst1_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rd0", cap0, 1'b0);
            chk("bp_rd1", cap1, 1'b0);
            chk("bp_valid", valid_out, 1'b0);
        end
        dst1_almost_full = 1'b0;
        for (int i = 2; i < 9; i++) begin
            tick();
            chk("bp_post_valid", valid_out, 1'b1);
            chk("bp_post_data", data_out, exp_bp[i]);
        end
        tick();
        chk("bp_idle", state, 3'd2);
        // error
        load(0, 6'h2A, 4);
        tick();
        tick();
        chk("err_pre_data", data_out, 6'h2A);
        fifo_error = 1'b1;
        tick();
        chk("err_rd", cap0, 1'b0);
        chk("err_state", state, 3'd4);
        chk("err_flag", error_out, 1'b1);
        fifo_error = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("err_sticky", state, 3'd4);
            chk("err_flag_sticky", error_out, 1'b1);
            chk("err_no_rd", cap0, 1'b0);
            chk("err_valid", valid_out, 1'b0);
        end
        reset_L = 1'b0;
        #1;
        chk("err_async_state", state, 3'd0);
        chk("err_async_flag", error_out, 1'b0);
        chk("err_async_alto", umbral_alto, 4'd0);
        q0.delete();
        refresh();
        #1;
        reset_L = 1'b1;
        init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd2;
        tick();
        chk("re_init", state, 3'd1);
        tick();
        chk("re_alto", umbral_alto, 4'd5);
        chk("re_bajo", umbral_bajo, 4'd2);
        init = 1'b0;
        tick();
        chk("re_idle", state, 3'd2);
        // init while active
        load(0, 6'h01, 6);
        load(1, 6'h3A, 3);
        tick();
        tick();
        chk("mid_d0", data_out, 6'h01);
        tick();
        chk("mid_d1", data_out, 6'h02);
        init = 1'b1; umbral_alto_in = 4'd7; umbral_bajo_in = 4'd4;
        tick();
        chk("mid_rd0", cap0, 1'b0);
        chk("mid_rd1", cap1, 1'b0);
        chk("mid_state", state, 3'd1);
        chk("mid_valid", valid_out, 1'b0);
        tick();
        chk("mid_alto", umbral_alto, 4'd7);
        chk("mid_bajo", umbral_bajo, 4'd4);
        init = 1'b0;
        tick();
        chk("mid_idle", state, 3'd2);
        tick();
        chk("mid_active", state, 3'd3);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("mid_valid_run", valid_out, 1'b1);
            chk("mid_data", data_out, exp_ini[i]);
        end
        tick();
        chk("mid_end_idle", state, 3'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
